// File: rtl/sr_latch_ctrl_if.sv
// Request/latch bundle for sr_latch_ctrl: requester handshake, latch drive lines and status.
// master = requesters plus the latch primitive; slave = the controller.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_set;
    logic [N_REQ-1:0] req_ready;
    logic             sbar;
    logic             rbar;
    logic             q;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_set, q,
        input  req_ready, sbar, rbar, busy, done, err
    );

    modport slave (
        input  req_valid, req_set, q,
        output req_ready, sbar, rbar, busy, done, err
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin owner of one NAND SR latch: timed active-low pulse, settle, done.
// Optional readback check of q against the requested value is enabled by SR_VERIFY_EN.
module sr_latch_ctrl #(
    parameter int N_REQ    = 2,
    parameter int PULSE_W  = 3,
    parameter int SETTLE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_ctrl_if.slave     bus
);
    localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_W);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic               op, op_nxt;

    logic [N_REQ-1:0]   ready_p0, ready_nxt;
    logic               sbar_p0, sbar_nxt;
    logic               rbar_p0, rbar_nxt;
    logic               busy_p0, busy_nxt;
    logic               done_p0, done_nxt;
    logic               err_p0, err_nxt;

    logic [IDX_W:0]     pick;
    logic               grant_hit;
    logic [IDX_W-1:0]   grant_idx;
    logic               mismatch;

    // {hit, index} of the first valid requester at or after start, wrapping upward
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] cand;
        logic [IDX_W:0]   res;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(start) + i) % N_REQ);
            if (!res[IDX_W] && valid[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign pick      = rr_pick(bus.req_valid, ptr);
    assign grant_hit = pick[IDX_W];
    assign grant_idx = pick[IDX_W-1:0];

`ifdef SR_VERIFY_EN
    logic q_sync_p0;
    logic q_sync_p1;

    // q is asynchronous to clk; two flops before it is compared
    always_ff @(posedge clk) begin
        q_sync_p0 <= bus.q;
        q_sync_p1 <= q_sync_p0;
    end

    assign mismatch = (q_sync_p1 != op);
`else
    logic unused_q;
    assign unused_q = bus.q;
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        op_nxt    = op;
        ready_nxt = '0;
        sbar_nxt  = 1'b1;
        rbar_nxt  = 1'b1;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (grant_hit) begin
                    state_nxt            = PULSE;
                    cnt_nxt              = CNT_W'(1);
                    ptr_nxt              = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    op_nxt               = bus.req_set[grant_idx];
                    ready_nxt[grant_idx] = 1'b1;
                    sbar_nxt             = ~bus.req_set[grant_idx];
                    rbar_nxt             = bus.req_set[grant_idx];
                end else begin
                    state_nxt = IDLE;
                end
            end
            PULSE: begin
                if (cnt == PULSE_END) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    sbar_nxt = ~op;
                    rbar_nxt = op;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_END) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    err_nxt   = mismatch;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            ready_p0 <= '0;
            sbar_p0  <= 1'b1;
            rbar_p0  <= 1'b1;
            busy_p0  <= 1'b0;
            done_p0  <= 1'b0;
            err_p0   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            ready_p0 <= ready_nxt;
            sbar_p0  <= sbar_nxt;
            rbar_p0  <= rbar_nxt;
            busy_p0  <= busy_nxt;
            done_p0  <= done_nxt;
            err_p0   <= err_nxt;
        end
    end

    // op only matters while a pulse is in flight, so it carries no reset
    always_ff @(posedge clk) begin
        op <= op_nxt;
    end

    assign bus.req_ready = ready_p0;
    assign bus.sbar      = sbar_p0;
    assign bus.rbar      = rbar_p0;
    assign bus.busy      = busy_p0;
    assign bus.done      = done_p0;
    assign bus.err       = err_p0;
endmodule
